// File: rtl/io_pkg.sv
// Shared definitions for the memory-mapped I/O port controller.
// Holds register offsets (derived from the output channel count), STATUS/CTRL bit
// positions and the FIFO count-width helper.
package io_pkg;

    // Register offsets relative to the controller base address.
    function automatic int unsigned in_data_offset(input int unsigned out_ch);
        return out_ch;
    endfunction

    function automatic int unsigned status_offset(input int unsigned out_ch);
        return out_ch + 1;
    endfunction

    function automatic int unsigned ctrl_offset(input int unsigned out_ch);
        return out_ch + 2;
    endfunction

    // A FIFO of depth D needs to represent 0..D, hence one bit more than the pointer.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

    // STATUS bit positions
    localparam int unsigned StatusEmptyBit = 0;
    localparam int unsigned StatusFullBit  = 1;
    localparam int unsigned StatusOvfBit   = 2;
    localparam int unsigned StatusUnfBit   = 3;
    localparam int unsigned StatusCountLsb = 8;

    // CTRL bit positions
    localparam int unsigned CtrlIrqEnBit = 0;
    localparam int unsigned CtrlFlushBit = 1;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with occupancy count.
// Ports:
//   clk, reset (async, active-low)
//   push/din  : store din when not full (a push while full is dropped)
//   pop       : advance head when not empty (a pop while empty is ignored)
//   flush     : empty the FIFO; takes priority over push and pop
//   dout      : current head entry (combinational)
//   count     : number of stored entries, 0..DEPTH
//   full/empty: occupancy flags, evaluated on the current (pre-edge) count
module io_sync_fifo
    import io_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            push,
    input  logic                            pop,
    input  logic                            flush,
    input  logic [DATA_W-1:0]               din,
    output logic [DATA_W-1:0]               dout,
    output logic [cnt_width(DEPTH)-1:0]     count,
    output logic                            full,
    output logic                            empty
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = cnt_width(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]   count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // DEPTH is a power of two, so pointer wrap is the natural overflow of PtrW bits.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; entries are only observable once pushed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

endmodule

// File: rtl/io_port_ctrl.sv
// Memory-mapped I/O port controller on the data-memory bus.
// Provides OUT_CH registered output channels and an IN_DEPTH-deep input capture FIFO
// with status, sticky overflow/underflow flags and a level interrupt.
// Ports:
//   clk, reset (async, active-low)
//   wr_en/rd_en/addr/wdata : bus access strobes, register address, write data
//   rdata/rvalid           : registered read data, valid one cycle after rd_en
//   in_data/in_strobe      : external sample captured into the FIFO
//   io_out                 : output channels, channel k at [k*DATA_W +: DATA_W]
//   irq                    : registered level interrupt
//   in_ready               : FIFO not full
module io_port_ctrl
    import io_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned OUT_CH   = 2,
    parameter int unsigned IN_DEPTH = 4,
    parameter int unsigned ADDR_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        addr,
    input  logic [DATA_W-1:0]        wdata,
    output logic [DATA_W-1:0]        rdata,
    output logic                     rvalid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_strobe,
    output logic [OUT_CH*DATA_W-1:0] io_out,
    output logic                     irq,
    output logic                     in_ready
);

    localparam int unsigned CntW = cnt_width(IN_DEPTH);

    localparam logic [ADDR_W-1:0] AddrInData = ADDR_W'(in_data_offset(OUT_CH));
    localparam logic [ADDR_W-1:0] AddrStatus = ADDR_W'(status_offset(OUT_CH));
    localparam logic [ADDR_W-1:0] AddrCtrl   = ADDR_W'(ctrl_offset(OUT_CH));

    logic [DATA_W-1:0] out_q [OUT_CH];
    logic [DATA_W-1:0] out_d [OUT_CH];
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              irq_en_q, irq_en_d;
    logic              irq_q, irq_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid_q;

    logic [OUT_CH-1:0] sel_out;
    logic              sel_in, sel_status, sel_ctrl;

    logic              fifo_pop, fifo_flush;
    logic [DATA_W-1:0] fifo_dout;
    logic [CntW-1:0]   fifo_count;
    logic              fifo_full, fifo_empty;

    logic [DATA_W-1:0] status_word, ctrl_word, rd_mux;

    // Address decode; addresses above CTRL select nothing.
    always_comb begin
        for (int k = 0; k < OUT_CH; k++) begin
            sel_out[k] = (addr == ADDR_W'(k));
        end
    end

    assign sel_in     = (addr == AddrInData);
    assign sel_status = (addr == AddrStatus);
    assign sel_ctrl   = (addr == AddrCtrl);

    assign fifo_pop   = rd_en && sel_in;
    assign fifo_flush = wr_en && sel_ctrl && wdata[CtrlFlushBit];

    io_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (in_strobe),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (in_data),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        status_word = '0;
        status_word[StatusEmptyBit]         = fifo_empty;
        status_word[StatusFullBit]          = fifo_full;
        status_word[StatusOvfBit]           = ovf_q;
        status_word[StatusUnfBit]           = unf_q;
        status_word[StatusCountLsb +: CntW] = fifo_count;

        ctrl_word = '0;
        ctrl_word[CtrlIrqEnBit] = irq_en_q;
    end

    // Read mux sees pre-write state, so a same-cycle write does not affect the read.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < OUT_CH; k++) begin
            if (sel_out[k]) rd_mux = out_q[k];
        end
        if (sel_in)     rd_mux = fifo_empty ? '0 : fifo_dout;
        if (sel_status) rd_mux = status_word;
        if (sel_ctrl)   rd_mux = ctrl_word;
    end

    always_comb begin
        for (int k = 0; k < OUT_CH; k++) begin
            out_d[k] = (wr_en && sel_out[k]) ? wdata : out_q[k];
        end

        irq_en_d = irq_en_q;
        if (wr_en && sel_ctrl) irq_en_d = wdata[CtrlIrqEnBit];

        // A new event in the same cycle as a W1C clear wins, so it is never lost.
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (wr_en && sel_status && wdata[StatusOvfBit]) ovf_d = 1'b0;
        if (wr_en && sel_status && wdata[StatusUnfBit]) unf_d = 1'b0;
        if (in_strobe && fifo_full) ovf_d = 1'b1;
        if (fifo_pop && fifo_empty) unf_d = 1'b1;

        rdata_d = rd_en ? rd_mux : rdata_q;
        irq_d   = irq_en_q && (!fifo_empty || ovf_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < OUT_CH; k++) begin
                out_q[k] <= '0;
            end
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            for (int k = 0; k < OUT_CH; k++) begin
                out_q[k] <= out_d[k];
            end
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            irq_en_q <= irq_en_d;
            irq_q    <= irq_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rd_en;
        end
    end

    always_comb begin
        for (int k = 0; k < OUT_CH; k++) begin
            io_out[k*DATA_W +: DATA_W] = out_q[k];
        end
    end

    assign rdata    = rdata_q;
    assign rvalid   = rvalid_q;
    assign irq      = irq_q;
    assign in_ready = !fifo_full;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Self-checking bench for io_port_ctrl: directed scenarios followed by random bus and
// strobe traffic, all compared against a queue-based behavioural model.
module tb_io_port_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned OC = 2;
    localparam int unsigned ID = 4;
    localparam int unsigned AW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en, rd_en, in_strobe;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata, in_data, rdata;
    logic             rvalid, irq, in_ready;
    logic [OC*DW-1:0] io_out;

    io_port_ctrl #(
        .DATA_W   (DW),
        .OUT_CH   (OC),
        .IN_DEPTH (ID),
        .ADDR_W   (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .rvalid    (rvalid),
        .in_data   (in_data),
        .in_strobe (in_strobe),
        .io_out    (io_out),
        .irq       (irq),
        .in_ready  (in_ready)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model
    logic [DW-1:0] mq [$];
    logic [DW-1:0] m_out [OC];
    bit            m_ovf, m_unf, m_irq_en, m_irq, m_rvalid;
    logic [DW-1:0] m_rdata;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] m_status();
        logic [DW-1:0] s = '0;
        s[0]    = (mq.size() == 0);
        s[1]    = (mq.size() == ID);
        s[2]    = m_ovf;
        s[3]    = m_unf;
        s[12:8] = 5'(mq.size());
        return s;
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < OC; k++) m_out[k] = '0;
        m_ovf = 0; m_unf = 0; m_irq_en = 0; m_irq = 0; m_rvalid = 0;
        m_rdata = '0;
    endtask

    // One bus/strobe cycle: drive, advance the model through the edge, sample #1 after.
    task automatic cycle(input bit we, input bit re, input int a, input logic [DW-1:0] wd,
                         input bit stb, input logic [DW-1:0] din);
        bit            full, empty;
        logic [DW-1:0] rv;
        wr_en = we; rd_en = re; addr = AW'(a); wdata = wd; in_strobe = stb; in_data = din;

        full  = (mq.size() == ID);
        empty = (mq.size() == 0);
        if (a < OC)            rv = m_out[a];
        else if (a == OC)      rv = empty ? '0 : mq[0];
        else if (a == OC + 1)  rv = m_status();
        else if (a == OC + 2)  rv = {31'b0, m_irq_en};
        else                   rv = '0;

        m_irq    = m_irq_en && (!empty || m_ovf);
        m_rvalid = re;
        if (re) m_rdata = rv;

        if (we && a == OC + 1) begin
            if (wd[2]) m_ovf = 0;
            if (wd[3]) m_unf = 0;
        end
        if (re && a == OC) begin
            if (empty) m_unf = 1;
            else       void'(mq.pop_front());
        end
        if (stb) begin
            if (full) m_ovf = 1;
            else      mq.push_back(din);
        end
        if (we && a < OC) m_out[a] = wd;
        if (we && a == OC + 2) begin
            m_irq_en = wd[0];
            if (wd[1]) mq.delete();
        end

        @(posedge clk);
        #1;
        wr_en = 0; rd_en = 0; in_strobe = 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [OC*DW-1:0] e;
        for (int k = 0; k < OC; k++) e[k*DW +: DW] = m_out[k];
        check({tag, ".rvalid"},   rvalid,   m_rvalid);
        check({tag, ".rdata"},    rdata,    m_rdata);
        check({tag, ".irq"},      irq,      m_irq);
        check({tag, ".in_ready"}, in_ready, mq.size() != ID);
        check({tag, ".io_out"},   io_out,   e);
    endtask

    task automatic idle();
        cycle(0, 0, 0, '0, 0, '0);
    endtask

    initial begin
        logic [DW-1:0] vals [4];
        vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33; vals[3] = 32'h44;

        reset = 0; wr_en = 0; rd_en = 0; addr = '0; wdata = '0;
        in_strobe = 0; in_data = '0;
        model_reset();
        #12;
        check_outputs("reset");
        check("reset.in_ready", in_ready, 1);
        @(negedge clk);
        reset = 1;
        @(posedge clk);
        #1;

        // Output channel write and readback
        cycle(1, 0, 1, 32'hDEADBEEF, 0, '0);
        check_outputs("out_wr");
        check("out_wr.hi", io_out[63:32], 32'hDEADBEEF);
        check("out_wr.lo", io_out[31:0], 0);
        cycle(0, 1, 1, '0, 0, '0);
        check("out_rd.rvalid", rvalid, 1);
        check("out_rd.rdata", rdata, 32'hDEADBEEF);
        idle();
        check("out_rd.rvalid_drop", rvalid, 0);
        check("out_rd.rdata_hold", rdata, 32'hDEADBEEF);

        // Fill, overflow, drain, underflow
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, '0, 1, vals[i]);
        check("fill.in_ready", in_ready, 0);
        cycle(0, 1, OC + 1, '0, 0, '0);
        check("fill.status", rdata, 32'h0000_0402);
        cycle(0, 0, 0, '0, 1, 32'h55);
        cycle(0, 1, OC + 1, '0, 0, '0);
        check("ovf.status", rdata, 32'h0000_0406);
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, OC, '0, 0, '0);
            check("drain.data", rdata, vals[i]);
        end
        cycle(0, 1, OC, '0, 0, '0);
        check("unf.data", rdata, 0);
        check_outputs("unf");
        cycle(0, 1, OC + 1, '0, 0, '0);
        check("unf.status", rdata, 32'h0000_000D);
        cycle(1, 0, OC + 1, 32'hC, 0, '0);
        cycle(0, 1, OC + 1, '0, 0, '0);
        check("w1c.status", rdata, 32'h0000_0001);

        // Simultaneous push and pop with 3 entries
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, '0, 1, 32'hA1 + i);
        cycle(0, 1, OC, '0, 1, 32'h99);
        check("pp.data", rdata, 32'hA1);
        cycle(0, 1, OC + 1, '0, 0, '0);
        check("pp.status", rdata, 32'h0000_0300);
        cycle(0, 1, OC, '0, 0, '0);
        check("pp.d1", rdata, 32'hA2);
        cycle(0, 1, OC, '0, 0, '0);
        check("pp.d2", rdata, 32'hA3);
        cycle(0, 1, OC, '0, 0, '0);
        check("pp.d3", rdata, 32'h99);

        // Interrupt behaviour
        cycle(1, 0, OC + 2, 32'h1, 0, '0);
        idle();
        check("irq.empty", irq, 0);
        cycle(0, 0, 0, '0, 1, 32'h7);
        idle();
        check("irq.push", irq, 1);
        cycle(0, 1, OC, '0, 0, '0);
        idle();
        check("irq.pop", irq, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0, 1, 32'h100 + i);
        for (int i = 0; i < 4; i++) cycle(0, 1, OC, '0, 0, '0);
        idle();
        check("irq.ovf", irq, 1);
        check_outputs("irq.ovf");
        cycle(1, 0, OC + 1, 32'h4, 0, '0);
        idle();
        check("irq.clr", irq, 0);

        // Flush with concurrent strobe; overflow set beforehand must survive
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, '0, 1, 32'h200 + i);
        for (int i = 0; i < 3; i++) cycle(0, 1, OC, '0, 0, '0);
        cycle(1, 0, OC + 2, 32'h3, 1, 32'h77);
        cycle(0, 1, OC + 1, '0, 0, '0);
        check("flush.status", rdata, 32'h0000_0005);
        check_outputs("flush");

        // Reset between rd_en and rvalid
        rd_en = 1; addr = AW'(OC + 1);
        #2 reset = 0;
        @(posedge clk);
        #1;
        check("rst.rvalid", rvalid, 0);
        check("rst.io_out", io_out, 0);
        check("rst.irq", irq, 0);
        @(negedge clk);
        reset = 1; rd_en = 0;
        model_reset();
        @(posedge clk);
        #1;
        cycle(0, 1, OC + 1, '0, 0, '0);
        check("rst.status", rdata, 32'h0000_0001);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            bit            we, re, stb;
            int            a;
            logic [DW-1:0] wd;
            we  = ($urandom_range(0, 3) == 0);
            re  = ($urandom_range(0, 2) == 0);
            a   = ($urandom_range(0, 2) == 0) ? OC : $urandom_range(0, 7);
            wd  = $urandom;
            if (a == OC + 2 && $urandom_range(0, 3) != 0) wd[1] = 1'b0;
            stb = ($urandom_range(0, 2) == 0);
            cycle(we, re, a, wd, stb, $urandom);
            check_outputs("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
